// File: rtl/cmd_word_aligner_pkg.sv
// Shared definitions for the command-stream word aligner.
//   SYNC_WORD_DEFAULT : frame pattern the aligner locks onto
//   BIT_CNT_W         : width of the in-frame bit position counter
//   align_state_e     : HUNT / VERIFY / LOCKED alignment states
//   sat_inc8          : 8-bit saturating increment
package cmd_word_aligner_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h817E;
    localparam int          BIT_CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_word_aligner.sv
// Command-path front end. Recovers 16-bit frames from the serial command
// stream (one already-sampled bit per clk160, MSB first) by aligning to
// SYNC_WORD, and forwards every non-sync frame once locked.
//
// Ports:
//   clk160        in   1   sole clock
//   rst           in   1   synchronous reset, active-high
//   data_in       in   1   serial command bit
//   data_out      out  16  recovered frame, holds between strobes
//   word_valid    out  1   one-cycle strobe per forwarded frame
//   locked        out  1   high while in LOCKED
//   sync_seen     out  1   one-cycle pulse per aligned sync frame
//   lock_loss_cnt out  8   LOCKED->HUNT transitions, saturating
//
// Output handshake: word_valid is a valid-only strobe with no ready. The
// consumer must take data_out in the cycle word_valid is high; there is no
// backpressure and at most one strobe occurs per 16 cycles.
module cmd_word_aligner
    import cmd_word_aligner_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
    parameter int          LOCK_SYNCS = 4,
    parameter int          MAX_GAP    = 64
) (
    input  logic        clk160,
    input  logic        rst,
    input  logic        data_in,
    output logic [15:0] data_out,
    output logic        word_valid,
    output logic        locked,
    output logic        sync_seen,
    output logic [7:0]  lock_loss_cnt
);

    localparam int MISS_W = $clog2(MAX_GAP + 1);
    localparam int SYNC_W = $clog2(LOCK_SYNCS + 1);

    align_state_e           state, state_n;
    logic [15:0]            sr, sr_next;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [SYNC_W-1:0]      sync_cnt, sync_cnt_n, sync_inc;
    logic [MISS_W-1:0]      miss_cnt, miss_cnt_n, miss_inc;
    logic [15:0]            data_out_n;
    logic                   word_valid_n;
    logic                   sync_seen_n;
    logic [7:0]             lock_loss_n;
    logic                   boundary;
    logic                   word_is_sync;
    logic                   sync_last;
    logic                   miss_last;

    always_comb begin
        sr_next      = {sr[14:0], data_in};
        // Frame boundary is the cycle whose sampled bit completes the frame.
        boundary     = (bit_cnt == {BIT_CNT_W{1'b1}});
        word_is_sync = (sr_next == SYNC_WORD);

        // Saturating counter steps and their terminal conditions.
        sync_inc  = (int'(sync_cnt) >= LOCK_SYNCS) ? sync_cnt : sync_cnt + 1'b1;
        miss_inc  = (int'(miss_cnt) >= MAX_GAP)    ? miss_cnt : miss_cnt + 1'b1;
        sync_last = (int'(sync_cnt) + 1 >= LOCK_SYNCS);
        miss_last = (int'(miss_cnt) + 1 >= MAX_GAP);

        state_n      = state;
        bit_cnt_n    = bit_cnt + 1'b1;
        sync_cnt_n   = sync_cnt;
        miss_cnt_n   = miss_cnt;
        data_out_n   = data_out;
        word_valid_n = 1'b0;
        sync_seen_n  = 1'b0;
        lock_loss_n  = lock_loss_cnt;

        case (state)
            ST_HUNT: begin
                // Any bit position may start a sync; re-phase the frame
                // counter so the next boundary is 16 bits later.
                if (word_is_sync) begin
                    bit_cnt_n  = '0;
                    sync_cnt_n = SYNC_W'(1);
                    miss_cnt_n = '0;
                    state_n    = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (boundary) begin
                    if (word_is_sync) begin
                        sync_cnt_n  = sync_inc;
                        miss_cnt_n  = '0;
                        sync_seen_n = 1'b1;
                        if (sync_last) state_n = ST_LOCKED;
                    end else begin
                        miss_cnt_n = miss_inc;
                        if (miss_last) state_n = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    if (word_is_sync) begin
                        miss_cnt_n  = '0;
                        sync_seen_n = 1'b1;
                    end else if (!miss_last) begin
                        data_out_n   = sr_next;
                        word_valid_n = 1'b1;
                        miss_cnt_n   = miss_inc;
                    end else begin
                        // The frame that exhausts the gap budget is dropped.
                        miss_cnt_n  = miss_inc;
                        state_n     = ST_HUNT;
                        lock_loss_n = sat_inc8(lock_loss_cnt);
                    end
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk160) begin
        if (rst) begin
            state         <= ST_HUNT;
            sr            <= '0;
            bit_cnt       <= '0;
            sync_cnt      <= '0;
            miss_cnt      <= '0;
            data_out      <= '0;
            word_valid    <= 1'b0;
            sync_seen     <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_n;
            sr            <= sr_next;
            bit_cnt       <= bit_cnt_n;
            sync_cnt      <= sync_cnt_n;
            miss_cnt      <= miss_cnt_n;
            data_out      <= data_out_n;
            word_valid    <= word_valid_n;
            sync_seen     <= sync_seen_n;
            lock_loss_cnt <= lock_loss_n;
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_cmd_word_aligner.sv
module tb_cmd_word_aligner;

    localparam logic [15:0] SYNC = 16'h817E;
    localparam int LOCK_SYNCS = 4;
    localparam int MAX_GAP    = 64;

    // ---------------- clock / reset ----------------
    logic clk160 = 1'b0;
    always #5 clk160 = ~clk160;

    logic        rst, data_in;
    logic [15:0] data_out;
    logic        word_valid, locked, sync_seen;
    logic [7:0]  lock_loss_cnt;

    // Small-parameter instance used for the lock-loss saturation test.
    logic        sat_rst, sat_data_in;
    logic [15:0] sat_data_out;
    logic        sat_word_valid, sat_locked, sat_sync_seen;
    logic [7:0]  sat_lock_loss_cnt;

    cmd_word_aligner dut (
        .clk160(clk160), .rst(rst), .data_in(data_in),
        .data_out(data_out), .word_valid(word_valid), .locked(locked),
        .sync_seen(sync_seen), .lock_loss_cnt(lock_loss_cnt)
    );

    cmd_word_aligner #(.LOCK_SYNCS(2), .MAX_GAP(2)) dut_sat (
        .clk160(clk160), .rst(sat_rst), .data_in(sat_data_in),
        .data_out(sat_data_out), .word_valid(sat_word_valid), .locked(sat_locked),
        .sync_seen(sat_sync_seen), .lock_loss_cnt(sat_lock_loss_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cnt_valid = 0;
    int cnt_seen  = 0;

    // ---------------- reference model (frame-level) ----------------
    logic [15:0] exp_q[$];
    logic [15:0] m_hist, m_data;
    bit          m_aligned, m_locked, m_valid, m_seen;
    int          m_phase, m_good, m_miss, m_loss;

    task automatic model_reset();
        m_hist = '0; m_data = '0;
        m_aligned = 0; m_locked = 0; m_valid = 0; m_seen = 0;
        m_phase = 0; m_good = 0; m_miss = 0; m_loss = 0;
        exp_q.delete();
    endtask

    // Applies one received bit: hunting looks at every 16-bit window, an
    // aligned stream is judged once every 16 bits.
    task automatic model_step(input bit b);
        m_hist  = {m_hist[14:0], b};
        m_valid = 0;
        m_seen  = 0;
        if (!m_aligned) begin
            if (m_hist == SYNC) begin
                m_aligned = 1; m_phase = 0; m_good = 1; m_miss = 0;
            end
        end else begin
            m_phase++;
            if (m_phase == 16) begin
                m_phase = 0;
                if (m_hist == SYNC) begin
                    m_miss = 0;
                    m_seen = 1;
                    if (!m_locked) begin
                        m_good++;
                        if (m_good >= LOCK_SYNCS) m_locked = 1;
                    end
                end else begin
                    m_miss++;
                    if (m_miss >= MAX_GAP) begin
                        m_aligned = 0;
                        if (m_locked) begin
                            m_locked = 0;
                            if (m_loss < 255) m_loss++;
                        end
                    end else if (m_locked) begin
                        m_valid = 1;
                        m_data  = m_hist;
                        exp_q.push_back(m_hist);
                    end
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_bit(input bit b, input bit bs = 1'b0);
        data_in     = b;
        sat_data_in = bs;
        model_step(b);
        @(posedge clk160);
        #1;
        check("word_valid", word_valid, m_valid);
        check("sync_seen", sync_seen, m_seen);
        check("locked", locked, m_locked);
        check("data_out", data_out, m_data);
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
        if (word_valid === 1'b1) begin
            cnt_valid++;
            if (exp_q.size() > 0) begin
                check("sb_word", data_out, exp_q.pop_front());
            end else begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got word %0h expected none", data_out);
            end
        end
        if (sync_seen === 1'b1) cnt_seen++;
    endtask

    task automatic send_frame(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_sat_frame(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(1'b0, w[i]);
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] w;
        w = 16'($urandom_range(0, 65535));
        if (w == SYNC) w = w ^ 16'h0001;
        return w;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] frame;
        bit          valid;
        bit          seen;
        bit          lck;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lock-up from a 5-bit offset, then alternating sync / data frames.
        vecs[0] = '{16'h817E, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{16'h817E, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{16'h817E, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{16'h817E, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[4] = '{16'hAAA2, 1'b1, 1'b0, 1'b1, 16'hAAA2};
        vecs[5] = '{16'h817E, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[6] = '{16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234};
        vecs[7] = '{16'h817E, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[8] = '{16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234};
        vecs[9] = '{16'h817E, 1'b0, 1'b1, 1'b1, 16'h0000};

        rst = 1'b1; data_in = 1'b0;
        sat_rst = 1'b1; sat_data_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk160);
        #1;
        check("rst_data_out", data_out, 16'h0);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_sync_seen", sync_seen, 1'b0);
        check("rst_lock_loss", lock_loss_cnt, 8'd0);
        check("rst_sat_locked", sat_locked, 1'b0);
        rst = 1'b0;
        sat_rst = 1'b0;

        // Table: lock, first word, alternating sync/data.
        repeat (5) send_bit(1'b0);
        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].frame);
            check($sformatf("tbl%0d_valid", i), word_valid, vecs[i].valid);
            check($sformatf("tbl%0d_seen", i), sync_seen, vecs[i].seen);
            check($sformatf("tbl%0d_locked", i), locked, vecs[i].lck);
            if (vecs[i].valid) check($sformatf("tbl%0d_data", i), data_out, vecs[i].data);
        end

        // Sync pattern straddling two data frames at a 3-bit offset.
        cnt_seen = 0; cnt_valid = 0;
        send_frame(16'h502F);
        check("offs_a_data", data_out, 16'h502F);
        send_frame(16'hC123);
        check("offs_b_data", data_out, 16'hC123);
        check("offs_seen_cnt", cnt_seen, 0);
        check("offs_valid_cnt", cnt_valid, 2);
        send_frame(SYNC);
        check("offs_phase_kept", sync_seen, 1'b1);

        // Gap timeout: 63 forwarded, 64th dropped along with lock.
        cnt_valid = 0;
        for (int i = 0; i < MAX_GAP; i++) send_frame(rand_data());
        check("gap_valid_cnt", cnt_valid, 63);
        check("gap_locked", locked, 1'b0);
        check("gap_loss_cnt", lock_loss_cnt, 8'd1);

        // Random phase, random traffic against the model.
        for (int r = 0; r < 3; r++) begin
            int junk;
            junk = $urandom_range(0, 15);
            for (int i = 0; i < junk; i++) send_bit(1'($urandom_range(0, 1)));
            repeat (LOCK_SYNCS) send_frame(SYNC);
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 3) == 0) send_frame(SYNC);
                else send_frame(rand_data());
            end
        end

        // Reset in the middle of a frame while locked.
        repeat (LOCK_SYNCS) send_frame(SYNC);
        check("pre_rst_locked", locked, 1'b1);
        for (int i = 15; i >= 9; i--) send_bit(1'(16'h5555 >> i));
        data_in = 1'b1;
        rst = 1'b1;
        @(posedge clk160);
        #1;
        model_reset();
        rst = 1'b0;
        check("mid_rst_data_out", data_out, 16'h0);
        check("mid_rst_valid", word_valid, 1'b0);
        check("mid_rst_locked", locked, 1'b0);
        check("mid_rst_seen", sync_seen, 1'b0);
        check("mid_rst_loss", lock_loss_cnt, 8'd0);
        repeat (3) send_frame(SYNC);
        check("relock_3_syncs", locked, 1'b0);
        send_frame(SYNC);
        check("relock_4_syncs", locked, 1'b1);
        send_frame(16'hBEEF);
        check("relock_word", data_out, 16'hBEEF);

        // Lock-loss saturation on the small-parameter instance.
        for (int k = 0; k < 256; k++) begin
            send_sat_frame(SYNC);
            send_sat_frame(SYNC);
            if (k == 0) check("sat_first_lock", sat_locked, 1'b1);
            send_sat_frame(16'h0000);
            send_sat_frame(16'h0000);
            if (k == 0) check("sat_loss_1", sat_lock_loss_cnt, 8'd1);
            if (k == 254) check("sat_loss_255", sat_lock_loss_cnt, 8'd255);
        end
        check("sat_loss_hold", sat_lock_loss_cnt, 8'd255);
        check("sat_unlocked", sat_locked, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
